data_mem_arbiter: RTL
=====================

DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 8, data memory address width.
REQ-002 SHALL have parameter DATA_BITS, default 8, data memory data width.
REQ-003 SHALL have parameter NUM_CONSUMERS, default 4, number of LSU requesters sharing one memory port.
REQ-004 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-005 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port consumer_read_valid  input  NUM_CONSUMERS  per-consumer read request.
REQ-007 SHALL have port consumer_read_address  input  NUM_CONSUMERS*ADDR_BITS  packed read addresses, consumer i at bits [i*ADDR_BITS +: ADDR_BITS].
REQ-008 SHALL have port consumer_read_ready  output  NUM_CONSUMERS  per-consumer read completion.
REQ-009 SHALL have port consumer_read_data  output  NUM_CONSUMERS*DATA_BITS  packed read data, same packing as REQ-007.
REQ-010 SHALL have port consumer_write_valid  input  NUM_CONSUMERS  per-consumer write request.
REQ-011 SHALL have port consumer_write_address  input  NUM_CONSUMERS*ADDR_BITS  packed write addresses.
REQ-012 SHALL have port consumer_write_data  input  NUM_CONSUMERS*DATA_BITS  packed write data.
REQ-013 SHALL have port consumer_write_ready  output  NUM_CONSUMERS  per-consumer write completion.
REQ-014 SHALL have ports mem_read_valid output 1, mem_read_address output ADDR_BITS, mem_read_ready input 1, mem_read_data input DATA_BITS: memory read channel.
REQ-015 SHALL have ports mem_write_valid output 1, mem_write_address output ADDR_BITS, mem_write_data output DATA_BITS, mem_write_ready input 1: memory write channel.
REQ-016 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-017 SHALL implement states IDLE, READ_WAIT, WRITE_WAIT, RELAY; at most one memory transaction outstanding.
REQ-018 In IDLE, SHALL scan consumers from rr_ptr upward modulo NUM_CONSUMERS and grant the first with read_valid or write_valid high.
REQ-019 If the granted consumer has both valids high, read SHALL win; its write is served on a later grant.
REQ-020 On grant in cycle T, SHALL latch consumer id, address and write data, and drive mem_read_valid or mem_write_valid high from cycle T+1; next state READ_WAIT or WRITE_WAIT.
REQ-021 On grant, rr_ptr SHALL become (granted id + 1) mod NUM_CONSUMERS.
REQ-022 In READ_WAIT/WRITE_WAIT, mem valid, address and data SHALL remain stable until the memory ready is sampled high.
REQ-023 On mem_read_ready high in cycle R, SHALL capture mem_read_data into that consumer's consumer_read_data slice, drop mem_read_valid and assert consumer_read_ready[id] from cycle R+1; next state RELAY.
REQ-024 On mem_write_ready high in cycle R, SHALL drop mem_write_valid and assert consumer_write_ready[id] from cycle R+1; next state RELAY.
REQ-025 In RELAY, the consumer ready SHALL stay high until the granted consumer's corresponding valid is sampled low; ready then drops next cycle and state returns to IDLE.
REQ-026 New arbitration SHALL NOT occur in the same cycle RELAY exits; earliest next grant is the first IDLE cycle.
REQ-027 consumer_read_data slices SHALL hold their value until the next read completion for that consumer.
REQ-028 At most one bit of consumer_read_ready | consumer_write_ready SHALL be high in any cycle.
REQ-029 A consumer valid deasserted before grant SHALL produce no memory transaction.
REQ-030 Memory ready asserted while the corresponding mem valid is low SHALL be ignored.

Reset
REQ-031 On reset, SHALL enter IDLE, set rr_ptr=0, and drive all valid, ready, busy, address, data outputs and read data slices to 0, abandoning any in-flight transaction.
REQ-032 Reset SHALL take effect asynchronously; first grant possible on the first rising edge after reset deassertion.

Verification
REQ-033 Single read: consumer 2 reads addr 0x10, memory returns 0x5A with 1 cycle ready delay -> mem_read_address=0x10, consumer_read_data[2]=0x5A, consumer_read_ready[2] high until valid drops.
REQ-034 Contention: consumers 0,1,3 all request writes simultaneously from reset -> memory writes served in order 0,1,3, then rr_ptr=0.
REQ-035 Fairness: consumer 0 re-requests immediately after each completion while consumer 1 waits -> grants alternate 0,1,0,1.
REQ-036 Read+write same consumer: consumer 1 asserts read 0x20 and write 0x21/0xAA -> read completes first, write on a later grant.
REQ-037 Stalled memory: mem_write_ready held low 10 cycles -> address/data stable, busy high, no other consumer granted.
REQ-038 Reset mid-READ_WAIT -> all outputs 0, busy 0, next request granted cleanly from rr_ptr=0.

Source files
------------

// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter that lets NUM_CONSUMERS load/store units share one data-memory port.
// Only one memory transaction is in flight at a time. The requester keeps its ready high until it drops its valid.
module data_mem_arbiter #(
    parameter int ADDR_BITS     = 8,
    parameter int DATA_BITS     = 8,
    parameter int NUM_CONSUMERS = 4
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [NUM_CONSUMERS-1:0]           consumer_read_valid,
    input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_address,
    output logic [NUM_CONSUMERS-1:0]           consumer_read_ready,
    output logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data,
    input  logic [NUM_CONSUMERS-1:0]           consumer_write_valid,
    input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_write_address,
    input  logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_write_data,
    output logic [NUM_CONSUMERS-1:0]           consumer_write_ready,
    output logic                               mem_read_valid,
    output logic [ADDR_BITS-1:0]               mem_read_address,
    input  logic                               mem_read_ready,
    input  logic [DATA_BITS-1:0]               mem_read_data,
    output logic                               mem_write_valid,
    output logic [ADDR_BITS-1:0]               mem_write_address,
    output logic [DATA_BITS-1:0]               mem_write_data,
    input  logic                               mem_write_ready,
    output logic                               busy
);

    localparam int ID_W = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;
    localparam logic [ID_W:0] NC = (ID_W+1)'(NUM_CONSUMERS);

    typedef enum logic [1:0] {IDLE, READ_WAIT, WRITE_WAIT, RELAY} state_t;

    state_t                             state_q, state_d;
    logic [ID_W-1:0]                    rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]                    id_q, id_d;
    logic                               is_read_q, is_read_d;
    logic [ADDR_BITS-1:0]               addr_q, addr_d;
    logic [DATA_BITS-1:0]               wdata_q, wdata_d;
    logic [NUM_CONSUMERS*DATA_BITS-1:0] rdata_q, rdata_d;

    logic [ID_W:0]              cand;
    logic [ID_W:0]              next_ptr;
    logic [ID_W-1:0]            gnt_id;
    logic                       gnt_found;
    logic [NUM_CONSUMERS-1:0]   id_onehot;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            rr_ptr_q  <= '0;
            id_q      <= '0;
            is_read_q <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            id_q      <= id_d;
            is_read_q <= is_read_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
        end
    end

    // Scan from rr_ptr upward with wrap-around; the first consumer with any valid wins.
    always_comb begin
        gnt_found = 1'b0;
        gnt_id    = '0;
        cand      = '0;
        for (int unsigned k = 0; k < NUM_CONSUMERS; k++) begin
            cand = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
            if (cand >= NC) cand = cand - NC;
            if (!gnt_found && (consumer_read_valid[cand[ID_W-1:0]] ||
                               consumer_write_valid[cand[ID_W-1:0]])) begin
                gnt_found = 1'b1;
                gnt_id    = cand[ID_W-1:0];
            end
        end
        next_ptr = {1'b0, gnt_id} + (ID_W+1)'(1);
    end

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        id_d      = id_q;
        is_read_d = is_read_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        unique case (state_q)
            IDLE: begin
                if (gnt_found) begin
                    id_d      = gnt_id;
                    rr_ptr_d  = (next_ptr == NC) ? '0 : next_ptr[ID_W-1:0];
                    wdata_d   = consumer_write_data[gnt_id*DATA_BITS +: DATA_BITS];
                    is_read_d = consumer_read_valid[gnt_id];
                    if (consumer_read_valid[gnt_id]) begin
                        addr_d  = consumer_read_address[gnt_id*ADDR_BITS +: ADDR_BITS];
                        state_d = READ_WAIT;
                    end else begin
                        addr_d  = consumer_write_address[gnt_id*ADDR_BITS +: ADDR_BITS];
                        state_d = WRITE_WAIT;
                    end
                end
            end
            READ_WAIT: begin
                if (mem_read_ready) begin
                    rdata_d[id_q*DATA_BITS +: DATA_BITS] = mem_read_data;
                    state_d = RELAY;
                end
            end
            WRITE_WAIT: begin
                if (mem_write_ready) state_d = RELAY;
            end
            RELAY: begin
                if (is_read_q ? !consumer_read_valid[id_q] : !consumer_write_valid[id_q])
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        id_onehot = '0;
        for (int unsigned i = 0; i < NUM_CONSUMERS; i++)
            id_onehot[i] = (id_q == ID_W'(i));
    end

    assign consumer_read_ready  = (state_q == RELAY &&  is_read_q) ? id_onehot : '0;
    assign consumer_write_ready = (state_q == RELAY && !is_read_q) ? id_onehot : '0;
    assign consumer_read_data   = rdata_q;
    assign mem_read_valid       = (state_q == READ_WAIT);
    assign mem_write_valid      = (state_q == WRITE_WAIT);
    assign mem_read_address     = addr_q;
    assign mem_write_address    = addr_q;
    assign mem_write_data       = wdata_q;
    assign busy                 = (state_q != IDLE);

endmodule
